// File: rtl/vdram_pkg.sv
// Shared types for the virtual DRAM logic die: controller main state, request
// entry layout and read-engine states.
package vdram_pkg;

  typedef enum logic [2:0] {
    MS_IDLE      = 3'd0,
    MS_ACTIVE    = 3'd1,
    MS_PRECHARGE = 3'd2,
    MS_READ      = 3'd3,
    MS_WRITE     = 3'd4,
    MS_REFRESH   = 3'd5
  } main_state_t;

  typedef enum logic {
    VDRAM_RD = 1'b0,
    VDRAM_WR = 1'b1
  } vdram_op_e;

  // Request fields are sized for the largest supported geometry; the die
  // zero-extends on push and slices back to its own widths at the head.
  localparam int REQ_BANK_W = 8;
  localparam int REQ_ROW_W  = 16;
  localparam int REQ_COL_W  = 16;

  typedef struct packed {
    vdram_op_e             op;
    logic [REQ_BANK_W-1:0] bank;
    logic [REQ_ROW_W-1:0]  row;
    logic [REQ_COL_W-1:0]  col;
  } vdram_req_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/vdram_bank_array.sv
// Storage for all banks: one write port, one read port, registered read data.
// Contents are deliberately not reset.
module vdram_bank_array #(
  parameter int AW    = 12,
  parameter int DEPTH = 4096,
  parameter int DW    = 1024
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vdram_multibank_logic_die.sv
// Multi-bank virtual DRAM die: per-bank open-row tracking, in-order request
// FIFO, write-data and read-return handshakes. Build option VDRAM_ROW_CHECK_EN
// rejects column commands to banks without an open row.
module vdram_multibank_logic_die
  import vdram_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int ROW_BITS  = 6,
  parameter int COL_BITS  = 4,
  parameter int DQ_BITS   = 1024,
  parameter int ADDR_BITS = 16,
  parameter int REQ_DEPTH = 4,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int LVL_W    = $clog2(REQ_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  main_state_t          state,
  input  logic [BANK_W-1:0]    bank,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 wdata_fifo_ren,
  input  logic [DQ_BITS-1:0]   data_all_out,
  input  logic                 read_data_buf_valid,
  output logic [DQ_BITS-1:0]   data_in,
  output logic                 rd_data_valid,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_row_closed
);

  localparam int PTR_W     = $clog2(REQ_DEPTH);
  localparam int MEM_AW    = BANK_W + ROW_BITS + COL_BITS;
  localparam int MEM_DEPTH = NUM_BANKS << (ROW_BITS + COL_BITS);

  // ---------------- row state ----------------
  logic [NUM_BANKS-1:0][ROW_BITS-1:0] open_row;
  logic [NUM_BANKS-1:0]               row_open;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_row <= '0;
      row_open <= '0;
    end else if (state == MS_ACTIVE) begin
      open_row[bank] <= addr[ROW_BITS-1:0];
      row_open[bank] <= 1'b1;
    end else if (state == MS_PRECHARGE) begin
      row_open[bank] <= 1'b0;
    end
  end

  // ---------------- request FIFO ----------------
  vdram_req_t             fifo_q [REQ_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  vdram_req_t             head, new_req;
  logic                   is_col, row_ok, push_req, push, pop;
  logic                   full, empty, head_rd, head_wr;
  logic                   wr_pend, wr_pop, rd_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign is_col = (state == MS_READ) || (state == MS_WRITE);
`ifdef VDRAM_ROW_CHECK_EN
  assign row_ok = row_open[bank];
`else
  assign row_ok = 1'b1;
`endif
  assign push_req = is_col && row_ok;
  assign full     = (fifo_level == LVL_W'(REQ_DEPTH));
  assign empty    = (fifo_level == '0);
  assign pop      = wr_pop || rd_pop;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push     = push_req && (!full || pop);

  assign new_req.op   = (state == MS_WRITE) ? VDRAM_WR : VDRAM_RD;
  assign new_req.bank = REQ_BANK_W'(bank);
  assign new_req.row  = REQ_ROW_W'(open_row[bank]);
  assign new_req.col  = REQ_COL_W'(addr[COL_BITS-1:0]);

  assign head    = fifo_q[rd_ptr];
  assign head_rd = !empty && (head.op == VDRAM_RD);
  assign head_wr = !empty && (head.op == VDRAM_WR);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= new_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------- write path ----------------
  // write data arrives the cycle after the controller pops its FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_pend <= 1'b0;
    else        wr_pend <= wdata_fifo_ren;
  end

  assign wr_pop = wr_pend && head_wr;

  // ---------------- read engine ----------------
  rd_state_e rd_st, rd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_st <= RD_IDLE;
    else        rd_st <= rd_nxt;
  end

  always_comb begin
    rd_nxt = rd_st;
    rd_pop = 1'b0;
    case (rd_st)
      RD_IDLE:  if (head_rd) begin
                  rd_pop = 1'b1;
                  rd_nxt = RD_ISSUE;
                end
      RD_ISSUE: rd_nxt = RD_HOLD;
      RD_HOLD:  if (read_data_buf_valid) rd_nxt = RD_IDLE;
      default:  rd_nxt = RD_IDLE;
    endcase
  end

  // ---------------- array ----------------
  logic [MEM_AW-1:0]  head_idx;
  logic [DQ_BITS-1:0] mem_rdata;

  assign head_idx = {head.bank[BANK_W-1:0], head.row[ROW_BITS-1:0], head.col[COL_BITS-1:0]};

  vdram_bank_array #(
    .AW   (MEM_AW),
    .DEPTH(MEM_DEPTH),
    .DW   (DQ_BITS)
  ) u_array (
    .clk  (clk),
    .we   (wr_pop),
    .waddr(head_idx),
    .wdata(data_all_out),
    .re   (rd_pop),
    .raddr(head_idx),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in       <= '0;
      rd_data_valid <= 1'b0;
    end else if (rd_st == RD_ISSUE) begin
      data_in       <= mem_rdata;
      rd_data_valid <= 1'b1;
    end else if ((rd_st == RD_HOLD) && read_data_buf_valid) begin
      rd_data_valid <= 1'b0;
    end
  end

  // ---------------- sticky errors ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_req && !push)  err_overflow  <= 1'b1;
      if (wr_pend && !head_wr) err_underflow <= 1'b1;
    end
  end

`ifdef VDRAM_ROW_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_row_closed <= 1'b0;
    else if (is_col && !row_open[bank]) err_row_closed <= 1'b1;
  end
`else
  assign err_row_closed = 1'b0;
`endif

  // request fields wider than this geometry and high address bits are don't-care
  logic unused_bits;
  assign unused_bits = ^{head, addr, row_open};

endmodule

// File: tb/tb_vdram_multibank_logic_die.sv
// Directed bench for vdram_multibank_logic_die: latency, bank isolation,
// overflow, underflow, row-closed handling and mid-operation reset.
module tb_vdram_multibank_logic_die;
  import vdram_pkg::*;

  localparam int DQ = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  main_state_t   state = MS_IDLE;
  logic [1:0]    bank = '0;
  logic [15:0]   addr = '0;
  logic          wren = 1'b0;
  logic [DQ-1:0] wdata = '0;
  logic          rbv = 1'b0;
  logic [DQ-1:0] data_in;
  logic          rd_data_valid;
  logic [2:0]    fifo_level;
  logic          err_overflow, err_underflow, err_row_closed;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  vdram_multibank_logic_die #(.DQ_BITS(DQ)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .state              (state),
    .bank               (bank),
    .addr               (addr),
    .wdata_fifo_ren     (wren),
    .data_all_out       (wdata),
    .read_data_buf_valid(rbv),
    .data_in            (data_in),
    .rd_data_valid      (rd_data_valid),
    .fifo_level         (fifo_level),
    .err_overflow       (err_overflow),
    .err_underflow      (err_underflow),
    .err_row_closed     (err_row_closed)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DQ-1:0] got, input logic [DQ-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input main_state_t s, input int b, input int a);
    state = s;
    bank  = 2'(b);
    addr  = 16'(a);
    step();
    state = MS_IDLE;
  endtask

  task automatic wr_data(input logic [DQ-1:0] d);
    wren = 1'b1;
    step();
    wren  = 1'b0;
    wdata = d;
    step();
    wdata = '0;
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!rd_data_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, DQ'(rd_data_valid), DQ'(1));
  endtask

  task automatic expect_rd(input string tag, input logic [DQ-1:0] d);
    wait_vld(tag);
    chk(tag, data_in, d);
    rbv = 1'b1;
    step();
    rbv = 1'b0;
  endtask

  function automatic logic [DQ-1:0] pat(input int c);
    logic [15:0] w;
    w = 16'hC000 + 16'(c);
    return {8{w}};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, data_in, '0);
    chk({tag, "_vld"},  DQ'(rd_data_valid), '0);
    chk({tag, "_lvl"},  DQ'(fifo_level), '0);
    chk({tag, "_ovf"},  DQ'(err_overflow), '0);
    chk({tag, "_unf"},  DQ'(err_underflow), '0);
    chk({tag, "_rc"},   DQ'(err_row_closed), '0);
  endtask

  initial begin
    logic [DQ-1:0] d1, d2, d3;
    d1 = {16{8'hA5}};
    d2 = {8{16'h1111}};
    d3 = {8{16'h2222}};

    step(); step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // basic write then read, with exact latency
    cmd(MS_ACTIVE, 2, 5);
    cmd(MS_WRITE, 2, 3);
    chk("t1_lvl_push", DQ'(fifo_level), DQ'(1));
    wr_data(d1);
    chk("t1_lvl_wr", DQ'(fifo_level), '0);
    cmd(MS_READ, 2, 3);
    chk("t1_lvl_rd", DQ'(fifo_level), DQ'(1));
    step();
    chk("t1_lvl_pop", DQ'(fifo_level), '0);
    chk("t1_vld_early", DQ'(rd_data_valid), '0);
    step();
    chk("t1_vld", DQ'(rd_data_valid), DQ'(1));
    chk("t1_data", data_in, d1);
    rbv = 1'b1;
    step();
    rbv = 1'b0;
    chk("t1_vld_clr", DQ'(rd_data_valid), '0);

    // two banks, same column: no aliasing, in-order returns
    cmd(MS_ACTIVE, 0, 1);
    cmd(MS_ACTIVE, 1, 7);
    cmd(MS_WRITE, 0, 0);
    cmd(MS_WRITE, 1, 0);
    chk("t2_lvl", DQ'(fifo_level), DQ'(2));
    wr_data(d2);
    wr_data(d3);
    cmd(MS_READ, 0, 0);
    cmd(MS_READ, 1, 0);
    expect_rd("t2_b0", d2);
    expect_rd("t2_b1", d3);

    // overflow: engine held by an unconsumed read, then REQ_DEPTH+1 reads
    for (int c = 0; c < 6; c++) begin
      cmd(MS_WRITE, 2, c);
      wr_data(pat(c));
    end
    cmd(MS_READ, 2, 0);
    step(); step();
    chk("t3_hold_vld", DQ'(rd_data_valid), DQ'(1));
    for (int c = 1; c < 5; c++) cmd(MS_READ, 2, c);
    chk("t3_lvl_full", DQ'(fifo_level), DQ'(4));
    chk("t3_ovf_pre", DQ'(err_overflow), '0);
    cmd(MS_READ, 2, 5);
    chk("t3_lvl_sat", DQ'(fifo_level), DQ'(4));
    chk("t3_ovf", DQ'(err_overflow), DQ'(1));
    for (int c = 0; c < 5; c++) expect_rd($sformatf("t3_rd%0d", c), pat(c));
    repeat (4) step();
    chk("t3_no_extra", DQ'(rd_data_valid), '0);
    chk("t3_lvl_empty", DQ'(fifo_level), '0);

    // underflow: write data with nothing queued
    chk("t4_unf_pre", DQ'(err_underflow), '0);
    wr_data({8{16'hDEAD}});
    chk("t4_unf", DQ'(err_underflow), DQ'(1));
    chk("t4_lvl", DQ'(fifo_level), '0);
    cmd(MS_READ, 2, 0);
    expect_rd("t4_unchanged", pat(0));
    chk("t4_ovf_sticky", DQ'(err_overflow), DQ'(1));

    // column access to a precharged bank
    cmd(MS_PRECHARGE, 3, 0);
    cmd(MS_READ, 3, 0);
`ifdef VDRAM_ROW_CHECK_EN
    chk("t5_lvl", DQ'(fifo_level), '0);
    chk("t5_rc", DQ'(err_row_closed), DQ'(1));
`else
    chk("t5_lvl", DQ'(fifo_level), DQ'(1));
    chk("t5_rc", DQ'(err_row_closed), '0);
    wait_vld("t5_rd");
    rbv = 1'b1;
    step();
    rbv = 1'b0;
`endif

    // reset with a return pending and two requests queued
    cmd(MS_READ, 2, 1);
    step(); step();
    chk("t6_vld", DQ'(rd_data_valid), DQ'(1));
    cmd(MS_READ, 2, 2);
    cmd(MS_READ, 2, 3);
    chk("t6_lvl", DQ'(fifo_level), DQ'(2));
    rst_n = 1'b0;
    step();
    chk_reset("t6_rst");
    rst_n = 1'b1;
    repeat (6) step();
    chk("t6_no_ret", DQ'(rd_data_valid), '0);
    chk("t6_lvl_post", DQ'(fifo_level), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/vdram_multibank_logic_die.md
# vdram_multibank_logic_die

Parametrised multi-bank virtual DRAM logic die for the controller-side simulation/emulation path. It decodes controller main-state commands (ACTIVE, PRECHARGE, READ, WRITE) and tracks one open row per bank. Column requests are queued in order in a request FIFO, with write data and read returns exchanged over the controller's write-data and read-buffer handshakes. It replaces the single-bank, fixed-geometry die model behind the DRAM controller backend and adds per-bank row state, sticky error flags and an explicit read-valid output.

## Interface
- NUM_BANKS, 4, bank count (power of 2, ≥1)
- ROW_BITS, 6, row address bits per bank
- COL_BITS, 4, column address bits
- DQ_BITS, 1024, data word width
- ADDR_BITS, 16, width of `addr` (≥ max(ROW_BITS, COL_BITS))
- REQ_DEPTH, 4, request FIFO entries (≥2)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- state  in  main_state_t  controller command for this cycle
- bank  in  max(1,$clog2(NUM_BANKS))  target bank of `state`
- addr  in  ADDR_BITS  row (ACTIVE) or column (READ/WRITE) in low bits
- wdata_fifo_ren  in  1  controller pops its write-data FIFO; `data_all_out` valid next cycle
- data_all_out  in  DQ_BITS  write data from controller
- read_data_buf_valid  in  1  controller consumes `data_in` this cycle
- data_in  out  DQ_BITS  read data to controller
- rd_data_valid  out  1  `data_in` holds an unconsumed read word
- fifo_level  out  $clog2(REQ_DEPTH+1)  queued requests
- err_overflow  out  1  sticky: request dropped, FIFO full
- err_underflow  out  1  sticky: write data with no write at head
- err_row_closed  out  1  sticky: READ/WRITE to a bank with no open row

## Operation
- ACTIVE: open_row[bank] <= addr[ROW_BITS-1:0], row_open[bank] <= 1. PRECHARGE: row_open[bank] <= 0. Other states are ignored.
- READ/WRITE: push {op, bank, open_row[bank], addr[COL_BITS-1:0]}. Row is captured at push time, so a later ACTIVE does not alter queued entries.
- Push accepted when not full, or when full with a pop in the same cycle. Otherwise the request is dropped and err_overflow is set.
- Write path: `wdata_fifo_ren` at cycle t registers a 1-cycle pending flag. At cycle t+1, if the head is a write, the block samples `data_all_out`, writes the array at {bank,row,col} and pops the head. If the head is not a write or the FIFO is empty, nothing is written and err_underflow is set.
- Read engine states: IDLE -> ISSUE -> HOLD -> IDLE.
  - IDLE: head is read -> pop, drive array read, go to ISSUE.
  - ISSUE: array output registered into `data_in`, rd_data_valid <= 1, go to HOLD.
  - HOLD: on `read_data_buf_valid` -> rd_data_valid <= 0, go to IDLE.
- Head is a write while the engine is IDLE: the engine waits for write data. Order is strict FIFO; a read after a write to the same address returns the new data.
- A read pop and a write pop never coincide, because the head is a single entry.
- `read_data_buf_valid` with rd_data_valid=0 is ignored.
- Error flags clear only on reset.

## Timing
- Reset values: data_in=0, rd_data_valid=0, fifo_level=0, all err_*=0, row_open=0, open_row=0, engine IDLE. Array contents are not reset.
- Reset mid-operation: FIFO, pending write flag and read engine are flushed immediately.
- Command at cycle t -> fifo_level increments at t+1; the entry is eligible at the head at t+1.
- Read latency: head read at cycle t -> data_in/rd_data_valid high from t+2. Minimum 3 cycles per read when consumed immediately.
- Write: `wdata_fifo_ren` at t -> array written at the t+1 edge -> a readable entry can issue at t+2.
- fifo_level = pushes − pops, saturating at 0 and REQ_DEPTH by construction.

## Configuration
- VDRAM_ROW_CHECK_EN defined: READ/WRITE to a bank with row_open=0 is not pushed and sets err_row_closed.
- VDRAM_ROW_CHECK_EN undefined: row_open is ignored; the request is pushed with the stale open_row value, and err_row_closed is tied to 0.

## Structure
- Shared package vdram_pkg holds:
  - main_state_t (shared with controller)
  - vdram_op_e {VDRAM_RD, VDRAM_WR}
  - vdram_req_t packed struct {op, bank, row, col}, parametrised by localparam widths
  - read-engine state enum
- Sub-module vdram_bank_array: synchronous 1-cycle-read memory of NUM_BANKS·2^(ROW_BITS+COL_BITS) × DQ_BITS words, with a write-enable port.
- The request FIFO is inline, as a circular buffer with read and write pointers.

## Test plan
- Reset then ACTIVE bank 2 row 5, WRITE col 3 with wdata_fifo_ren then data 0xA5…, READ col 3 -> rd_data_valid two cycles after the read reaches the head, data_in=0xA5…, cleared on read_data_buf_valid.
- ACTIVE bank 0 row 1 and bank 1 row 7; write distinct data to bank0/col0 and bank1/col0; read both -> no aliasing, returns in issue order.
- Push REQ_DEPTH+1 READs with no consumption -> fifo_level=REQ_DEPTH, err_overflow=1, the extra request absent from the returns.
- wdata_fifo_ren with an empty FIFO -> err_underflow=1, array unchanged (a subsequent read returns the prior value).
- PRECHARGE bank 3 then READ bank 3 -> with VDRAM_ROW_CHECK_EN: err_row_closed=1, fifo_level stays 0; without: the request is queued.
- Assert rst_n low while rd_data_valid=1 with 2 queued requests -> next cycle all outputs at reset values, no further returns.
